// File: rtl/bus_transfer_sequencer_if.sv
// rtl/bus_transfer_sequencer_if.sv - request and enable signals between control unit, sequencer and bus mux
interface bus_transfer_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic        flush;
    logic [25:0] src_out;
    logic [23:0] dst_in;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output req_valid, req_src, req_dst, flush,
        input  req_ready, src_out, dst_in, done, err, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst, flush,
        output req_ready, src_out, dst_in, done, err, busy
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - queued register-transfer sequencer driving one-hot bus source/destination enables
module bus_transfer_sequencer #(
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      clear,
    bus_transfer_sequencer_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [3:0]    CNT_INIT = 4'(SETTLE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [4:0]    r_cur_src;
    logic [4:0]    r_cur_dst;
    logic          r_err;
    logic [4:0]    r_fifo_src [FIFO_DEPTH];
    logic [4:0]    r_fifo_dst [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic [4:0] w_head_src;
    logic [4:0] w_head_dst;
    logic       w_head_legal;

    assign bus.req_ready = (r_count != FULL);
    assign w_push        = bus.req_valid && bus.req_ready && !bus.flush;
    assign w_pop         = ((r_state == S_IDLE) || (r_state == S_LATCH)) &&
                           (r_count != '0) && !bus.flush;
    assign w_head_src    = r_fifo_src[r_rd_ptr];
    assign w_head_dst    = r_fifo_dst[r_rd_ptr];
    assign w_head_legal  = (w_head_src <= 5'd25) && (w_head_dst <= 5'd23);

    // Queue storage needs no reset: count/pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_src[r_wr_ptr] <= bus.req_src;
            r_fifo_dst[r_wr_ptr] <= bus.req_dst;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_cur_src <= 5'd0;
            r_cur_dst <= 5'd0;
            r_err     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_err <= 1'b0;
            if (bus.flush) begin
                r_state  <= S_IDLE;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase

                case (r_state)
                    S_DRIVE: begin
                        if (r_cnt == 4'd0) r_state <= S_LATCH;
                        else               r_cnt   <= r_cnt - 4'd1;
                    end
                    S_IDLE, S_LATCH: begin
                        // A legal head starts the next transfer with no idle gap.
                        if (w_pop && w_head_legal) begin
                            r_cur_src <= w_head_src;
                            r_cur_dst <= w_head_dst;
                            r_cnt     <= CNT_INIT;
                            r_state   <= S_DRIVE;
                        end else begin
                            r_err   <= w_pop;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.src_out = ((r_state == S_DRIVE) || (r_state == S_LATCH)) ? (26'd1 << r_cur_src) : 26'd0;
    assign bus.dst_in  = (r_state == S_LATCH) ? (24'd1 << r_cur_dst) : 24'd0;
    assign bus.done    = (r_state == S_LATCH);
    assign bus.err     = r_err;
    assign bus.busy    = (r_state != S_IDLE) || (r_count != '0);
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - directed checks of bus_transfer_sequencer with SETTLE=1 and SETTLE=4
module tb_bus_transfer_sequencer;
    logic clock;
    logic clear;
    int   n_vec;
    int   n_err;

    bus_transfer_sequencer_if ba ();
    bus_transfer_sequencer_if bb ();

    bus_transfer_sequencer #(.SETTLE(1), .FIFO_DEPTH(2)) u_a (
        .clock (clock),
        .clear (clear),
        .bus   (ba)
    );

    bus_transfer_sequencer #(.SETTLE(4), .FIFO_DEPTH(2)) u_b (
        .clock (clock),
        .clear (clear),
        .bus   (bb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [25:0] s, input logic [23:0] d,
                         input logic dn, input logic bz);
        check({tag, ".src"},  32'(ba.src_out), 32'(s));
        check({tag, ".dst"},  32'(ba.dst_in),  32'(d));
        check({tag, ".done"}, 32'(ba.done),    32'(dn));
        check({tag, ".busy"}, 32'(ba.busy),    32'(bz));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear = 1'b0;
        ba.req_valid = 0; ba.req_src = 0; ba.req_dst = 0; ba.flush = 0;
        bb.req_valid = 0; bb.req_src = 0; bb.req_dst = 0; bb.flush = 0;
        #2;
        chk_a("rst", 26'd0, 24'd0, 1'b0, 1'b0);
        check("rst.ready", 32'(ba.req_ready), 32'd1);
        check("rst.err",   32'(ba.err),       32'd0);
        check("rst.b_src", 32'(bb.src_out),   32'd0);
        tick();
        clear = 1'b1;

        // 1: MDR -> R3
        ba.req_valid = 1; ba.req_src = 5'd21; ba.req_dst = 5'd3;
        tick();
        ba.req_valid = 0;
        chk_a("t1.q",     26'd0,       24'd0,     1'b0, 1'b1);
        tick(); chk_a("t1.drv",   26'd1 << 21, 24'd0,     1'b0, 1'b1);
        tick(); chk_a("t1.latch", 26'd1 << 21, 24'd1 << 3, 1'b1, 1'b1);
        tick(); chk_a("t1.idle",  26'd0,       24'd0,     1'b0, 1'b0);

        // 2: three back-to-back requests into a 2-deep queue
        ba.req_valid = 1; ba.req_src = 5'd1; ba.req_dst = 5'd4;
        tick(); check("t2.rdy0", 32'(ba.req_ready), 32'd1);
        ba.req_src = 5'd2; ba.req_dst = 5'd5;
        tick(); check("t2.rdy1", 32'(ba.req_ready), 32'd1);
        chk_a("t2.drvA", 26'd1 << 1, 24'd0, 1'b0, 1'b1);
        ba.req_src = 5'd3; ba.req_dst = 5'd6;
        tick(); ba.req_valid = 0;
        check("t2.full", 32'(ba.req_ready), 32'd0);
        chk_a("t2.latA", 26'd1 << 1, 24'd1 << 4, 1'b1, 1'b1);
        tick(); check("t2.rdy2", 32'(ba.req_ready), 32'd1);
        chk_a("t2.drvB", 26'd1 << 2, 24'd0, 1'b0, 1'b1);
        tick(); chk_a("t2.latB", 26'd1 << 2, 24'd1 << 5, 1'b1, 1'b1);
        tick(); chk_a("t2.drvC", 26'd1 << 3, 24'd0, 1'b0, 1'b1);
        tick(); chk_a("t2.latC", 26'd1 << 3, 24'd1 << 6, 1'b1, 1'b1);
        tick(); chk_a("t2.idle", 26'd0, 24'd0, 1'b0, 1'b0);

        // 3: illegal source code, then a legal request
        ba.req_valid = 1; ba.req_src = 5'd26; ba.req_dst = 5'd2;
        tick(); ba.req_valid = 0;
        check("t3.err0", 32'(ba.err), 32'd0);
        tick(); check("t3.err1", 32'(ba.err), 32'd1);
        chk_a("t3.noen", 26'd0, 24'd0, 1'b0, 1'b0);
        ba.req_valid = 1; ba.req_src = 5'd7; ba.req_dst = 5'd8;
        tick(); ba.req_valid = 0;
        check("t3.err2", 32'(ba.err), 32'd0);
        tick(); chk_a("t3.drv",   26'd1 << 7, 24'd0,      1'b0, 1'b1);
        tick(); chk_a("t3.latch", 26'd1 << 7, 24'd1 << 8, 1'b1, 1'b1);
        tick(); chk_a("t3.idle",  26'd0,      24'd0,      1'b0, 1'b0);

        // 4: SETTLE=4, PC -> MAR
        bb.req_valid = 1; bb.req_src = 5'd20; bb.req_dst = 5'd20;
        tick(); bb.req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t4.src%0d", i), 32'(bb.src_out), 32'(26'd1 << 20));
            check($sformatf("t4.dst%0d", i), 32'(bb.dst_in),  32'd0);
        end
        tick();
        check("t4.src_lat", 32'(bb.src_out), 32'(26'd1 << 20));
        check("t4.dst_lat", 32'(bb.dst_in),  32'(24'd1 << 20));
        check("t4.done",    32'(bb.done),    32'd1);
        tick();
        check("t4.idle", 32'(bb.src_out), 32'd0);

        // 5: asynchronous reset mid-DRIVE with one entry queued
        ba.req_valid = 1; ba.req_src = 5'd1; ba.req_dst = 5'd1;
        tick(); ba.req_src = 5'd2; ba.req_dst = 5'd2;
        tick(); ba.req_valid = 0;
        chk_a("t5.drv", 26'd1 << 1, 24'd0, 1'b0, 1'b1);
        #2 clear = 1'b0;
        #1;
        chk_a("t5.rst", 26'd0, 24'd0, 1'b0, 1'b0);
        check("t5.ready", 32'(ba.req_ready), 32'd1);
        clear = 1'b1;
        tick(); chk_a("t5.after", 26'd0, 24'd0, 1'b0, 1'b0);

        // 6: flush in DRIVE with one entry queued
        ba.req_valid = 1; ba.req_src = 5'd3; ba.req_dst = 5'd9;
        tick(); ba.req_src = 5'd4; ba.req_dst = 5'd10;
        tick(); ba.req_valid = 0;
        chk_a("t6.drv", 26'd1 << 3, 24'd0, 1'b0, 1'b1);
        ba.flush = 1;
        tick(); ba.flush = 0;
        chk_a("t6.fl", 26'd0, 24'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("t6.q%0d", i), 26'd0, 24'd0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
